// File: rtl/aes_pkg.sv
// Shared types and byte-layout helpers for the serial InvShiftRows block.
// The state is column-major: s[r][c] sits at bits [127-8*(4c+r) -: 8].
package aes_pkg;
    localparam int COL_CNT_W = 2;

    typedef logic [127:0] state_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } fsm_t;

    function automatic int byte_msb(input int c, input int r);
        return 127 - 8 * (4 * c + r);
    endfunction
endpackage

// File: rtl/inv_row_shifting.sv
// Pure byte permutation: out[r][c] = in[r][(c-r) mod 4], i.e. row r rotated
// right by r positions.
module inv_row_shifting
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = byte_msb(c, r);
            localparam int SRC = byte_msb((c - r + 4) % 4, r);
            assign o_state[DST -: 8] = i_state[SRC -: 8];
        end
    end
endmodule

// File: rtl/inv_shift_rows_serial.sv
// Collects four 32-bit state columns, then holds the InvShiftRows result
// until the downstream handshake. in_ready depends only on registered state.
module inv_shift_rows_serial
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_state,
    output logic [COL_CNT_W-1:0] col_cnt
);
    fsm_t                  r_state;
    fsm_t                  w_next_state;
    logic [COL_CNT_W-1:0]  r_col_cnt;
    logic [2:0][31:0]      r_cols;
    logic [127:0]          r_out_state;
    logic [127:0]          w_block;
    logic [127:0]          w_shifted;
    logic                  w_capture;
    logic                  w_last;

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == FULL);
    assign out_state = r_out_state;
    assign col_cnt   = r_col_cnt;

    assign w_capture = in_valid && (r_state == COLLECT) && !flush;
    assign w_last    = w_capture && (r_col_cnt == 2'd3);

    // The fourth column feeds the permutation straight from in_word.
    assign w_block = {r_cols[0], r_cols[1], r_cols[2], in_word};

    inv_row_shifting u_inv_row_shifting (
        .i_state (w_block),
        .o_state (w_shifted)
    );

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (w_last)    w_next_state = FULL;
                FULL:    if (out_ready) w_next_state = COLLECT;
                default:                w_next_state = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_cnt   <= '0;
            r_cols      <= '0;
            r_out_state <= '0;
        end else if (flush) begin
            r_col_cnt <= '0;
            r_cols    <= '0;
        end else if (w_capture) begin
            if (w_last) begin
                r_col_cnt   <= '0;
                r_out_state <= w_shifted;
            end else begin
                r_col_cnt <= r_col_cnt + 2'd1;
                for (int i = 0; i < 3; i++) begin
                    if (r_col_cnt == COL_CNT_W'(i)) r_cols[i] <= in_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Scoreboard bench: the driver queues expected blocks, a negedge monitor
// pops and compares on every output handshake.
module tb_inv_shift_rows_serial;
    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [1:0]   col_cnt;

    inv_shift_rows_serial dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .col_cnt   (col_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] exp;
        logic [127:0] inp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    rand_rdy = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [127:0] inv_ref(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] fwd_ref(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    // Inputs only change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [31:0] w);
        bit done = 0;
        in_valid = 1'b1;
        in_word  = w;
        for (int k = 0; k < 200 && !done; k++) begin
            done = in_ready;
            tick();
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: word %h not accepted", w);
        end
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [127:0] exp, input logic [127:0] inp);
        item_t it;
        it.exp = exp;
        it.inp = inp;
        sb.push_back(it);
    endtask

    logic [127:0] held_val;
    bit           held = 0;

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else if (out_valid) begin
            if (held) chk("hold_stable", out_state, held_val);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_state);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("out_state", out_state, it.exp);
                    chk("fwd_recovers_input", fwd_ref(out_state), it.inp);
                end
                held = 0;
            end else begin
                held     = 1;
                held_val = out_state;
            end
        end else begin
            held = 0;
        end
    end

    localparam logic [127:0] BLK_IN  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] BLK_EXP = 128'h000D0A07_04010E0B_0805020F_0C090603;

    initial begin
        logic [127:0] blk;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_col_cnt", 128'(col_cnt), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst = 1'b0;
        tick();

        // Back-to-back block, single-cycle output pulse.
        push(BLK_EXP, BLK_IN);
        blk = BLK_IN;
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32]);
        chk("latency_out_valid", 128'(out_valid), 128'd1);
        chk("full_in_ready", 128'(in_ready), 128'd0);
        tick();
        chk("pulse_out_valid", 128'(out_valid), 128'd0);
        chk("after_hs_in_ready", 128'(in_ready), 128'd1);

        // Backpressure: held 10 cycles, junk in_valid ignored.
        out_ready = 1'b0;
        push(BLK_EXP, BLK_IN);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32]);
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            chk("stall_in_ready", 128'(in_ready), 128'd0);
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", 128'(in_ready), 128'd1);
        chk("release_col_cnt", 128'(col_cnt), 128'd0);

        // Mid-block gap keeps partial columns.
        push(BLK_EXP, BLK_IN);
        send_word(blk[127:96]);
        send_word(blk[95:64]);
        for (int i = 0; i < 7; i++) begin
            chk("gap_col_cnt", 128'(col_cnt), 128'd2);
            tick();
        end
        send_word(blk[63:32]);
        send_word(blk[31:0]);
        tick();

        // Flush after three words; next block must be clean.
        send_word(blk[127:96]);
        send_word(blk[95:64]);
        send_word(blk[63:32]);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 32'h11111111;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_col_cnt", 128'(col_cnt), 128'd0);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        push({16{8'hFF}}, {16{8'hFF}});
        for (int i = 0; i < 4; i++) send_word(32'hFFFFFFFF);
        tick();

        // Async reset while FULL drops the block.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(32'hA5A5A5A5 ^ i);
        chk("pre_rst_out_valid", 128'(out_valid), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_col_cnt", 128'(col_cnt), 128'd0);
        chk("async_rst_in_ready", 128'(in_ready), 128'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        push(BLK_EXP, BLK_IN);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32]);
        tick();

        // Random blocks with random gaps and backpressure.
        rand_rdy = 1;
        for (int b = 0; b < 100; b++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            push(inv_ref(blk), blk);
            for (int i = 0; i < 4; i++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                send_word(blk[127-32*i -: 32]);
            end
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 500 && sb.size() != 0; k++) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d blocks outstanding, expected 0", sb.size());
        end
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
